add_sub_bist: RTL
=================

# add_sub_bist

Self-test sequencer for the `adder_subtractor` datapath. On a start pulse it drives a fixed schedule of operand and mode vectors into the datapath, one vector per clock. It compares each returned result against an internally computed expected value and reports an error count plus a pass/fail flag. It sits beside the `adder_subtractor` instance and replaces the software vector loop with synthesizable hardware, so the same check runs on silicon or FPGA.

## Interface
Parameters:
- `SIZE`, 8: operand width; result width is `SIZE+1`.
- `NUM_VECT`, 100: number of vectors per run (1..65535).

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  run request, sampled on the rising edge of `clk_i`.
- `mode_o`  out  1  operation select to the datapath: 1 = add, 0 = subtract (a−b).
- `a_o`  out  `SIZE`  signed operand A to the datapath.
- `b_o`  out  `SIZE`  signed operand B to the datapath.
- `c_i`  in  `SIZE+1`  signed result from the datapath (combinational from `mode_o`/`a_o`/`b_o`).
- `busy_o`  out  1  run in progress.
- `done_o`  out  1  run complete; results valid.
- `pass_o`  out  1  `done_o` && `error_count_o`==0.
- `error_count_o`  out  16  mismatch count, saturating at 0xFFFF.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: if `start_i`, go to RUN.
  - RUN: when the last vector is checked, go to DONE.
  - DONE: if `start_i`, go to RUN.
- Entering RUN:
  - Clear index to 0.
  - Clear `error_count_o`.
  - Load vector 0 onto outputs.
  - Clear the mod-10 phase counter.
- Vector schedule for index i (mode register starts at 0):
  - The mode register toggles on loading any index with i mod 10 == 5.
  - mode 1: a = i, b = i−5.
  - mode 0: a = 5, b = i.
  - Operands are truncated to `SIZE` bits (two's complement).
- Expected result:
  - Sign-extend a and b to `SIZE+1` bits, then add or subtract per mode.
  - The value is registered alongside the operands.
- Each RUN cycle:
  - Compare `c_i` to the registered expected value.
  - On mismatch, `error_count_o` += 1, unless it is already 0xFFFF.
  - If index == `NUM_VECT`−1, go to DONE; otherwise increment the index and load the next vector.
- `start_i` during RUN is ignored.
- In DONE:
  - `mode_o`, `a_o` and `b_o` hold the last vector.
  - `error_count_o` holds its value until the next start.
- Index counter width is ceil(log2(`NUM_VECT`)), minimum 1.

## Timing
- Reset (async assert, sync-safe deassert):
  - State goes to IDLE.
  - `mode_o`=0, `a_o`=0, `b_o`=0.
  - `busy_o`=0, `done_o`=0, `pass_o`=0, `error_count_o`=0.
- Reset asserted mid-run aborts immediately to the reset values; no partial result is retained.
- Start at edge T:
  - Vector 0 appears on the outputs after T, and `busy_o`=1.
  - Vector k is checked at edge T+1+k.
  - `done_o`=1 and `busy_o`=0 after edge T+`NUM_VECT`.
  - Total latency is `NUM_VECT` cycles.
- The datapath path `a_o`/`b_o`/`mode_o` → `c_i` must settle within one clock period.
- `done_o` and `pass_o` stay high until a new start or reset.
  - On restart they drop in the same cycle `busy_o` rises.
- If `start_i` is held high continuously, runs repeat back-to-back, with one DONE cycle between them.

## Configuration
- `ADD_SUB_BIST_FIRST_FAIL_EN` defined:
  - Adds output `fail_idx_o` (16 bits): index of the first mismatching vector in the current run.
  - Adds output `fail_val_o` (`SIZE+1` bits): the `c_i` value observed at that vector.
  - Both are captured only when `error_count_o` goes from 0 to 1.
  - Both are cleared by reset and on start.
  - Both hold 0 if no failure occurred.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

## Test plan
- Correct `adder_subtractor` (`SIZE`=8) connected, start pulse →
  - `done_o` rises 100 cycles later.
  - `error_count_o`=0, `pass_o`=1.
- Output sequence check after start (correct datapath) →
  - cycle 1: mode 0, a=5, b=0.
  - index 5: mode 1, a=5, b=0, expected 5.
  - index 15: mode 0, a=5, b=15, expected −10.
  - index 85: mode 1, a=85, b=80, expected 165.
  - index 99: mode 0, expected −94.
- `c_i` tied to 0 →
  - `error_count_o`=100, `pass_o`=0.
  - With FIRST_FAIL: `fail_idx_o`=0, `fail_val_o`=0.
- Faulty datapath that always subtracts →
  - `error_count_o`=49 (every mode-1 vector except index 5), `pass_o`=0.
  - With FIRST_FAIL: `fail_idx_o`=6, `fail_val_o`=5.
- `rst_ni` pulsed low at index 40 →
  - All outputs go to 0 immediately, state is IDLE.
  - A subsequent start gives a clean 100-cycle run with `pass_o`=1.
- `start_i` pulsed mid-run → ignored; `start_i` held high → second run starts after one DONE cycle with the counter cleared.

Source files
------------

// File: rtl/add_sub_bist.sv
// add_sub_bist: self-test sequencer for the adder_subtractor datapath.
//
// On a start request it drives a fixed schedule of operand/mode vectors, one per clock,
// compares each returned result with an internally computed expected value, and reports a
// saturating mismatch count plus a pass flag.
//
// Optional feature macro: ADD_SUB_BIST_FIRST_FAIL_EN
//   Adds fail_idx_o / fail_val_o, which record the index and observed c_i of the first
//   mismatching vector in the current run.
//
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   start_i        run request (ignored while a run is in progress)
//   mode_o         operation select to datapath: 1 = add, 0 = subtract (a - b)
//   a_o, b_o       signed operands to datapath
//   c_i            signed SIZE+1 bit result from datapath (combinational)
//   busy_o         run in progress
//   done_o         run complete, results valid
//   pass_o         done_o and zero mismatches
//   error_count_o  mismatch count, saturating at 16'hFFFF
//   fail_idx_o     (optional) index of first mismatching vector
//   fail_val_o     (optional) c_i observed at that vector
module add_sub_bist #(
  parameter int unsigned SIZE     = 8,
  parameter int unsigned NUM_VECT = 100
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  output logic            mode_o,
  output logic [SIZE-1:0] a_o,
  output logic [SIZE-1:0] b_o,
  input  logic [SIZE:0]   c_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic [15:0]     error_count_o
`ifdef ADD_SUB_BIST_FIRST_FAIL_EN
  ,
  output logic [15:0]     fail_idx_o,
  output logic [SIZE:0]   fail_val_o
`endif
);

  localparam int unsigned     IdxW    = (NUM_VECT > 1) ? $clog2(NUM_VECT) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_VECT - 1);
  localparam logic [SIZE-1:0] Five    = SIZE'(5);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e r_state, w_state_next;

  logic [IdxW-1:0] r_idx;
  logic [3:0]      r_phase;  // index mod 10, tracked incrementally to avoid a divider
  logic            r_mode;
  logic [SIZE-1:0] r_a, r_b;
  logic [SIZE:0]   r_exp;
  logic [15:0]     r_err;

  logic            w_start_run, w_last, w_step, w_load, w_mismatch;
  logic [IdxW-1:0] w_ld_idx;
  logic [3:0]      w_ld_phase;
  logic            w_ld_mode;
  logic [SIZE-1:0] w_ld_a, w_ld_b;
  logic [SIZE:0]   w_ld_exp, w_ld_a_sx, w_ld_b_sx;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign w_start_run = start_i && (r_state != StRun);
  assign w_last      = (r_idx == LastIdx);
  assign w_step      = (r_state == StRun) && !w_last;
  assign w_load      = w_start_run || w_step;
  assign w_mismatch  = (r_state == StRun) && (c_i != r_exp);

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start_i) w_state_next = StRun;
      StRun:   if (w_last)  w_state_next = StDone;
      StDone:  if (start_i) w_state_next = StRun;
      default: w_state_next = StIdle;
    endcase
  end

  // Next vector to load: index 0 on start, otherwise the successor of the current index.
  always_comb begin
    w_ld_idx   = w_start_run ? '0 : r_idx + IdxW'(1);
    w_ld_phase = 4'd0;
    if (!w_start_run) begin
      w_ld_phase = (r_phase == 4'd9) ? 4'd0 : r_phase + 4'd1;
    end
    // Mode flips whenever the loaded index lands on phase 5; each run starts in subtract.
    w_ld_mode = w_start_run ? 1'b0 : ((w_ld_phase == 4'd5) ? ~r_mode : r_mode);
    if (w_ld_mode) begin
      w_ld_a = SIZE'(w_ld_idx);
      w_ld_b = SIZE'(w_ld_idx) - Five;
    end else begin
      w_ld_a = Five;
      w_ld_b = SIZE'(w_ld_idx);
    end
    w_ld_a_sx = {w_ld_a[SIZE-1], w_ld_a};
    w_ld_b_sx = {w_ld_b[SIZE-1], w_ld_b};
    w_ld_exp  = w_ld_mode ? (w_ld_a_sx + w_ld_b_sx) : (w_ld_a_sx - w_ld_b_sx);
  end

  // Vector, expected value and error accumulation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx   <= '0;
      r_phase <= 4'd0;
      r_mode  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_exp   <= '0;
      r_err   <= 16'd0;
    end else begin
      if (w_load) begin
        r_idx   <= w_ld_idx;
        r_phase <= w_ld_phase;
        r_mode  <= w_ld_mode;
        r_a     <= w_ld_a;
        r_b     <= w_ld_b;
        r_exp   <= w_ld_exp;
      end
      if (w_start_run) begin
        r_err <= 16'd0;
      end else if (w_mismatch && (r_err != 16'hFFFF)) begin
        r_err <= r_err + 16'd1;
      end
    end
  end

`ifdef ADD_SUB_BIST_FIRST_FAIL_EN
  logic [15:0]   r_fail_idx;
  logic [SIZE:0] r_fail_val;

  // Capture only on the 0 -> 1 transition of the error count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fail_idx <= 16'd0;
      r_fail_val <= '0;
    end else if (w_start_run) begin
      r_fail_idx <= 16'd0;
      r_fail_val <= '0;
    end else if (w_mismatch && (r_err == 16'd0)) begin
      r_fail_idx <= 16'(r_idx);
      r_fail_val <= c_i;
    end
  end

  assign fail_idx_o = r_fail_idx;
  assign fail_val_o = r_fail_val;
`endif

  assign mode_o        = r_mode;
  assign a_o           = r_a;
  assign b_o           = r_b;
  assign busy_o        = (r_state == StRun);
  assign done_o        = (r_state == StDone);
  assign pass_o        = done_o && (r_err == 16'd0);
  assign error_count_o = r_err;

endmodule
